axi4_mgr: RTL and testbench
===========================

Name: axi4_mgr

Overview:
- Minimal AXI4 manager bridging a simple request/response port to an AXI4 bus interface (`AXI_BUS`, manager side).
- Issues independent single-beat writes (post-processing data `pp_data_i` to `axi_wr_addr_i`) and single-beat reads (from `axi_rd_addr_i`, returned on `dla_data_o`).
- Sits between the datapath/accelerator and the system interconnect.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width; must match the `pp_if` interface.
- AXI_DATA_WIDTH, 64, AXI data width (power of two, >= 8); must match the `pp_if` interface.
- ID and user widths are taken from the connected interface; all ID and user fields are driven to 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset; synchronous, active-low.
- req_i  in  2  request; bit 0 = write request, bit 1 = read request; level-sensitive.
- axi_wr_addr_i  in  AXI_ADDR_WIDTH  write target address.
- axi_rd_addr_i  in  AXI_ADDR_WIDTH  read source address.
- pp_data_i  in  AXI_DATA_WIDTH  write data.
- rsp_o  out  2  completion pulses; bit 0 = write done, bit 1 = read done.
- dla_data_o  out  AXI_DATA_WIDTH  last read data.
- pp_if  AXI_BUS manager modport  -  AXI4 bus.

Behaviour:
- Single clock domain.
- Synchronous active-low reset, sampled on the rising clk_i edge. On reset:
  - all AXI valid outputs = 0, bready/rready = 0;
  - rsp_o = 0, dla_data_o = 0;
  - both FSMs go to IDLE.
- Reset mid-operation aborts the transaction immediately; no completion pulse is produced.
- Constant AW/AR fields:
  - len = 0, size = log2(AXI_DATA_WIDTH/8), burst = INCR (2'b01);
  - id = 0, lock = 0, cache = 0, prot = 0, qos = 0, region = 0, user = 0;
  - atop = 0.
- Constant W fields: wstrb = all ones, wlast = 1.
- Write FSM: W_IDLE -> W_REQ -> W_RESP -> W_DONE -> W_IDLE.
  - W_IDLE: if req_i[0]=1, latch axi_wr_addr_i and pp_data_i, then go to W_REQ.
  - W_REQ: awvalid and wvalid both asserted from the same cycle. Each valid is deasserted individually on its own handshake (valid & ready). Go to W_RESP once both handshakes have occurred; simultaneous and either-order handshakes are all legal.
  - W_RESP: bready = 1. On bvalid go to W_DONE.
  - W_DONE: rsp_o[0] = 1 for exactly one cycle, then W_IDLE.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_DONE -> R_IDLE.
  - R_IDLE: if req_i[1]=1, latch axi_rd_addr_i, then go to R_ADDR.
  - R_ADDR: arvalid = 1 until arready.
  - R_DATA: rready = 1. On rvalid, register rdata into dla_data_o and go to R_DONE.
  - R_DONE: rsp_o[1] = 1 for one cycle, then R_IDLE.
- Latched addresses and data are used for the whole transaction; input changes after acceptance are ignored.
- dla_data_o holds its value until the next read data beat.
- Read and write FSMs are fully independent and may overlap. req_i = 2'b11 starts both in the same cycle.
- Request held high: a new transaction starts the cycle after DONE (back-to-back). Minimum period is 4 cycles with zero-wait subordinate.
- Valid signals never depend combinationally on ready (AXI rule).
- bresp/rresp values other than OKAY still complete normally (rsp pulse produced; read data captured).

Optional Feature:
- Macro: AXI4_MGR_ERR_EN.
- When defined:
  - extra output `err_o[1:0]` (bit 0 = write, bit 1 = read);
  - a bit is set when bresp/rresp != OKAY on the completing handshake;
  - a bit is cleared when a new transaction of the same type starts or on reset;
  - reset value 0.
- When undefined: no `err_o` port; response codes are ignored.

Test Plan:
- Reset for 2 cycles -> rsp_o=00, dla_data_o=0, awvalid/wvalid/arvalid=0, held throughout reset.
- req_i=01, axi_wr_addr_i=0x5000, pp_data_i=0xDEADBEEF0B501E7E, zero-wait subordinate -> expected:
  - AW: awaddr=0x5000, len=0, size=3, burst=INCR;
  - W: wdata=0xDEADBEEF0B501E7E, wstrb=0xFF, wlast=1;
  - single rsp_o[0] pulse after B.
- req_i=10, axi_rd_addr_i=0x6000, subordinate returns 0x0123456789ABCDEF -> araddr=0x6000; dla_data_o=0x0123456789ABCDEF; rsp_o[1] pulses once.
- req_i=11 held, randomized-delay subordinate (ready/valid stalls, AW and W accepted in different cycles) -> repeated overlapping transactions, no protocol violation, one rsp pulse per completed B/R.
- Reset asserted while in W_RESP/R_DATA -> all valids/readies low next cycle, no rsp pulse; restart works after reset release.
- With AXI4_MGR_ERR_EN: subordinate returns SLVERR on B -> err_o[0]=1 with rsp_o[0] pulse; next write start clears it.

Source files
------------

// File: rtl/axi4_mgr_if.sv
// rtl/axi4_mgr_if.sv - AXI_BUS interface (AXI4 channels with manager/subordinate modports)
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport manager (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport subordinate (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi4_mgr.sv
// rtl/axi4_mgr.sv - single-beat AXI4 manager with independent write/read FSMs; optional err_o via AXI4_MGR_ERR_EN
module axi4_mgr #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [1:0]                req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr_i,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0] pp_data_i,
    output logic [1:0]                rsp_o,
    output logic [AXI_DATA_WIDTH-1:0] dla_data_o,
`ifdef AXI4_MGR_ERR_EN
    output logic [1:0]                err_o,
`endif
    AXI_BUS.manager                   pp_if
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q;
    logic [AXI_DATA_WIDTH-1:0] wr_data_q;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_q;
    logic                      aw_done_q;
    logic                      w_done_q;

    // Valids and readies are pure functions of registered state, never of ready.
    logic aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic wr_start, rd_start;

    assign wr_start = (w_state_q == W_IDLE) && req_i[0];
    assign rd_start = (r_state_q == R_IDLE) && req_i[1];

    assign aw_valid = (w_state_q == W_REQ) && !aw_done_q;
    assign w_valid  = (w_state_q == W_REQ) && !w_done_q;
    assign b_ready  = (w_state_q == W_RESP);
    assign ar_valid = (r_state_q == R_ADDR);
    assign r_ready  = (r_state_q == R_DATA);

    assign aw_hs = aw_valid && pp_if.aw_ready;
    assign w_hs  = w_valid && pp_if.w_ready;
    assign b_hs  = b_ready && pp_if.b_valid;
    assign ar_hs = ar_valid && pp_if.ar_ready;
    assign r_hs  = r_ready && pp_if.r_valid;

    assign rsp_o = {r_state_q == R_DONE, w_state_q == W_DONE};

    // Write FSM next state: AW and W may complete in either order or together.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: if (req_i[0]) w_state_d = W_REQ;
            W_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) w_state_d = W_RESP;
            W_RESP: if (pp_if.b_valid) w_state_d = W_DONE;
            W_DONE: w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write state, latched request and per-channel handshake flags.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            w_state_q <= W_IDLE;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (wr_start) begin
                wr_addr_q <= axi_wr_addr_i;
                wr_data_q <= pp_data_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE: if (req_i[1]) r_state_d = R_ADDR;
            R_ADDR: if (pp_if.ar_ready) r_state_d = R_DATA;
            R_DATA: if (pp_if.r_valid) r_state_d = R_DONE;
            R_DONE: r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read state, latched address and returned data (held until the next beat).
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state_q  <= R_IDLE;
            rd_addr_q  <= '0;
            dla_data_o <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (rd_start) rd_addr_q <= axi_rd_addr_i;
            if (r_hs) dla_data_o <= pp_if.r_data;
        end
    end

`ifdef AXI4_MGR_ERR_EN
    logic [1:0] err_q;

    // Error flags: cleared at the start of a same-type transaction, set on a non-OKAY response.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            err_q <= 2'b00;
        end else begin
            if (wr_start)  err_q[0] <= 1'b0;
            else if (b_hs) err_q[0] <= (pp_if.b_resp != 2'b00);
            if (rd_start)  err_q[1] <= 1'b0;
            else if (r_hs) err_q[1] <= (pp_if.r_resp != 2'b00);
        end
    end

    assign err_o = err_q;

    logic unused_rsp;
    assign unused_rsp = &{1'b0, pp_if.b_id, pp_if.b_user, pp_if.r_id, pp_if.r_last, pp_if.r_user};
`else
    logic unused_rsp;
    assign unused_rsp = &{1'b0, b_hs, pp_if.b_id, pp_if.b_user, pp_if.b_resp,
                          pp_if.r_id, pp_if.r_last, pp_if.r_user, pp_if.r_resp};
`endif

    assign pp_if.aw_id     = '0;
    assign pp_if.aw_addr   = wr_addr_q;
    assign pp_if.aw_len    = 8'd0;
    assign pp_if.aw_size   = AXI_SIZE;
    assign pp_if.aw_burst  = 2'b01;
    assign pp_if.aw_lock   = 1'b0;
    assign pp_if.aw_cache  = 4'd0;
    assign pp_if.aw_prot   = 3'd0;
    assign pp_if.aw_qos    = 4'd0;
    assign pp_if.aw_region = 4'd0;
    assign pp_if.aw_atop   = 6'd0;
    assign pp_if.aw_user   = '0;
    assign pp_if.aw_valid  = aw_valid;

    assign pp_if.w_data    = wr_data_q;
    assign pp_if.w_strb    = '1;
    assign pp_if.w_last    = 1'b1;
    assign pp_if.w_user    = '0;
    assign pp_if.w_valid   = w_valid;

    assign pp_if.b_ready   = b_ready;

    assign pp_if.ar_id     = '0;
    assign pp_if.ar_addr   = rd_addr_q;
    assign pp_if.ar_len    = 8'd0;
    assign pp_if.ar_size   = AXI_SIZE;
    assign pp_if.ar_burst  = 2'b01;
    assign pp_if.ar_lock   = 1'b0;
    assign pp_if.ar_cache  = 4'd0;
    assign pp_if.ar_prot   = 3'd0;
    assign pp_if.ar_qos    = 4'd0;
    assign pp_if.ar_region = 4'd0;
    assign pp_if.ar_user   = '0;
    assign pp_if.ar_valid  = ar_valid;

    assign pp_if.r_ready   = r_ready;

endmodule

// File: tb/tb_axi4_mgr.sv
// tb/tb_axi4_mgr.sv - directed self-checking bench for axi4_mgr with a configurable AXI subordinate model
module tb_axi4_mgr;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req;
    logic [31:0] wr_addr;
    logic [31:0] rd_addr;
    logic [63:0] pp_data;
    logic [1:0]  rsp;
    logic [63:0] dla_data;
`ifdef AXI4_MGR_ERR_EN
    logic [1:0]  err;
`endif

    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) bus ();

    axi4_mgr #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .req_i         (req),
        .axi_wr_addr_i (wr_addr),
        .axi_rd_addr_i (rd_addr),
        .pp_data_i     (pp_data),
        .rsp_o         (rsp),
        .dla_data_o    (dla_data),
`ifdef AXI4_MGR_ERR_EN
        .err_o         (err),
`endif
        .pp_if         (bus)
    );

    // Subordinate configuration.
    logic        stall = 1'b0;
    logic        hold_b = 1'b0;
    logic        hold_r = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [63:0] rdata_cfg = 64'h0;

    // Subordinate-observed values and statistics.
    logic [31:0] cap_awaddr, cap_araddr;
    logic [7:0]  cap_awlen, cap_arlen;
    logic [2:0]  cap_awsize, cap_arsize;
    logic [1:0]  cap_awburst, cap_arburst;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wstrb;
    logic        cap_wlast;
    logic [31:0] cap_awmisc, cap_armisc;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, split_cnt = 0, viol_cnt = 0;
    logic aw_got, w_got, ar_got;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_araddr;
    logic [63:0] p_wdata;

    assign bus.b_id   = '0;
    assign bus.b_user = '0;
    assign bus.r_id   = '0;
    assign bus.r_last = 1'b1;
    assign bus.r_user = '0;

    logic awh, wh, arh;
    assign awh = bus.aw_valid && bus.aw_ready;
    assign wh  = bus.w_valid && bus.w_ready;
    assign arh = bus.ar_valid && bus.ar_ready;

    // AXI subordinate model with optional random stalls, plus valid-stability monitor.
    always @(posedge clk) begin
        if (!rstn) begin
            bus.aw_ready <= 1'b0; bus.w_ready <= 1'b0; bus.ar_ready <= 1'b0;
            bus.b_valid <= 1'b0; bus.b_resp <= 2'b00;
            bus.r_valid <= 1'b0; bus.r_resp <= 2'b00; bus.r_data <= 64'h0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
        end else begin
            if (p_awv && !p_awr && (!bus.aw_valid || bus.aw_addr != p_awaddr)) viol_cnt <= viol_cnt + 1;
            if (p_wv && !p_wr && (!bus.w_valid || bus.w_data != p_wdata)) viol_cnt <= viol_cnt + 1;
            if (p_arv && !p_arr && (!bus.ar_valid || bus.ar_addr != p_araddr)) viol_cnt <= viol_cnt + 1;
            p_awv <= bus.aw_valid; p_awr <= bus.aw_ready; p_awaddr <= bus.aw_addr;
            p_wv <= bus.w_valid; p_wr <= bus.w_ready; p_wdata <= bus.w_data;
            p_arv <= bus.ar_valid; p_arr <= bus.ar_ready; p_araddr <= bus.ar_addr;

            bus.aw_ready <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.w_ready  <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ar_ready <= stall ? 1'($urandom_range(0, 1)) : 1'b1;

            if (awh) begin
                cap_awaddr <= bus.aw_addr; cap_awlen <= bus.aw_len; cap_awsize <= bus.aw_size;
                cap_awburst <= bus.aw_burst;
                cap_awmisc <= {5'd0, bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_qos,
                               bus.aw_region, bus.aw_atop, bus.aw_id, bus.aw_user};
                aw_cnt <= aw_cnt + 1; aw_got <= 1'b1;
            end
            if (wh) begin
                cap_wdata <= bus.w_data; cap_wstrb <= bus.w_strb; cap_wlast <= bus.w_last;
                w_cnt <= w_cnt + 1; w_got <= 1'b1;
            end
            if (awh != wh) split_cnt <= split_cnt + 1;
            if (!bus.b_valid && !hold_b && (aw_got || awh) && (w_got || wh) &&
                (!stall || $urandom_range(0, 1) == 1)) begin
                bus.b_valid <= 1'b1; bus.b_resp <= bresp_cfg;
            end
            if (bus.b_valid && bus.b_ready) begin
                bus.b_valid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= b_cnt + 1;
            end

            if (arh) begin
                cap_araddr <= bus.ar_addr; cap_arlen <= bus.ar_len; cap_arsize <= bus.ar_size;
                cap_arburst <= bus.ar_burst;
                cap_armisc <= {6'd0, bus.ar_lock, bus.ar_cache, bus.ar_prot, bus.ar_qos,
                               bus.ar_region, bus.ar_id, bus.ar_user};
                ar_cnt <= ar_cnt + 1; ar_got <= 1'b1;
            end
            if (!bus.r_valid && !hold_r && (ar_got || arh) && (!stall || $urandom_range(0, 1) == 1)) begin
                bus.r_valid <= 1'b1; bus.r_data <= rdata_cfg; bus.r_resp <= rresp_cfg;
            end
            if (bus.r_valid && bus.r_ready) begin
                bus.r_valid <= 1'b0; ar_got <= 1'b0; r_cnt <= r_cnt + 1;
            end
        end
    end

    // Completion pulse counters and pulse spacing.
    int cyc = 0;
    int wr_pulses = 0, rd_pulses = 0;
    int last_wr = 0, last_rd = 0, wr_gap = 0, rd_gap = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rsp[0]) begin wr_pulses++; wr_gap = cyc - last_wr; last_wr = cyc; end
        if (rsp[1]) begin rd_pulses++; rd_gap = cyc - last_rd; last_rd = cyc; end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One-cycle request pulse, then enough idle cycles to complete with a zero-wait subordinate.
    task automatic pulse_req(input logic [1:0] r);
        @(negedge clk) req = r;
        @(negedge clk) req = 2'b00;
        repeat (8) @(negedge clk);
    endtask

    int w0, r0, b0, rc0, a0, ar0;

    initial begin
        rstn = 1'b0; req = 2'b00;
        wr_addr = 32'h0; rd_addr = 32'h0; pp_data = 64'h0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_rsp", {62'd0, rsp}, 64'h0);
            check("reset_dla", dla_data, 64'h0);
            check("reset_valids", {59'd0, bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 64'h0);
        end
        rstn = 1'b1;
        @(negedge clk);

        // Single write, inputs changed after acceptance.
        w0 = wr_pulses;
        @(negedge clk) begin req = 2'b01; wr_addr = 32'h5000; pp_data = 64'hDEADBEEF0B501E7E; end
        @(negedge clk) begin req = 2'b00; wr_addr = 32'hFFFF0000; pp_data = 64'h1111111111111111; end
        repeat (8) @(negedge clk);
        check("awaddr", cap_awaddr, 64'h5000);
        check("awlen", cap_awlen, 64'h0);
        check("awsize", cap_awsize, 64'h3);
        check("awburst", cap_awburst, 64'h1);
        check("aw_const", cap_awmisc, 64'h0);
        check("wdata", cap_wdata, 64'hDEADBEEF0B501E7E);
        check("wstrb", cap_wstrb, 64'hFF);
        check("wlast", cap_wlast, 64'h1);
        check("wr_pulses", wr_pulses - w0, 64'd1);

        // Single read.
        r0 = rd_pulses;
        rdata_cfg = 64'h0123456789ABCDEF;
        rd_addr = 32'h6000;
        pulse_req(2'b10);
        check("araddr", cap_araddr, 64'h6000);
        check("arlen_size_burst", {cap_arlen, 5'd0, cap_arsize, 6'd0, cap_arburst}, {8'd0, 5'd0, 3'd3, 6'd0, 2'd1});
        check("ar_const", cap_armisc, 64'h0);
        check("dla_data", dla_data, 64'h0123456789ABCDEF);
        check("rd_pulses", rd_pulses - r0, 64'd1);
        rdata_cfg = 64'h5555;
        repeat (4) @(negedge clk);
        check("dla_hold", dla_data, 64'h0123456789ABCDEF);

        // Back-to-back with request held: 4-cycle period.
        rdata_cfg = 64'h0A0B0C0D;
        @(negedge clk) req = 2'b11;
        repeat (14) @(negedge clk);
        req = 2'b00;
        repeat (8) @(negedge clk);
        check("wr_gap", wr_gap, 64'd4);
        check("rd_gap", rd_gap, 64'd4);

        // Non-OKAY responses still complete.
        w0 = wr_pulses; r0 = rd_pulses;
        bresp_cfg = 2'b10; rresp_cfg = 2'b10; rdata_cfg = 64'hBAD0BAD0CAFEF00D;
        pulse_req(2'b11);
        check("slverr_wr_pulse", wr_pulses - w0, 64'd1);
        check("slverr_rd_pulse", rd_pulses - r0, 64'd1);
        check("slverr_rdata", dla_data, 64'hBAD0BAD0CAFEF00D);
`ifdef AXI4_MGR_ERR_EN
        check("err_set", {62'd0, err}, 64'h3);
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        pulse_req(2'b01);
        check("err_wr_clear", {62'd0, err}, 64'h2);
        pulse_req(2'b10);
        check("err_rd_clear", {62'd0, err}, 64'h0);
`endif
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;

        // Overlapping traffic with a randomly stalling subordinate.
        stall = 1'b1; rdata_cfg = 64'hA5A5A5A5A5A5A5A5;
        w0 = wr_pulses; r0 = rd_pulses; b0 = b_cnt; rc0 = r_cnt; a0 = aw_cnt; ar0 = ar_cnt;
        @(negedge clk) req = 2'b11;
        repeat (300) @(negedge clk);
        req = 2'b00;
        repeat (100) @(negedge clk);
        stall = 1'b0;
        check("ovl_wr_vs_b", wr_pulses - w0, b_cnt - b0);
        check("ovl_rd_vs_r", rd_pulses - r0, r_cnt - rc0);
        check("ovl_aw_vs_b", aw_cnt - a0, b_cnt - b0);
        check("ovl_ar_vs_r", ar_cnt - ar0, r_cnt - rc0);
        check("ovl_progress", {63'd0, (wr_pulses - w0) > 4 && (rd_pulses - r0) > 4}, 64'h1);
        check("ovl_split", {63'd0, split_cnt > 0}, 64'h1);
        check("ovl_violations", viol_cnt, 64'd0);
        check("ovl_rdata", dla_data, 64'hA5A5A5A5A5A5A5A5);

        // Reset while waiting for B and R.
        hold_b = 1'b1; hold_r = 1'b1;
        wr_addr = 32'h1234; rd_addr = 32'h4321;
        @(negedge clk) req = 2'b11;
        @(negedge clk) req = 2'b00;
        repeat (3) @(negedge clk);
        check("midrst_waiting", {62'd0, bus.b_ready, bus.r_ready}, 64'h3);
        w0 = wr_pulses; r0 = rd_pulses;
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_valids", {59'd0, bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 64'h0);
        check("midrst_rsp", {62'd0, rsp}, 64'h0);
        @(negedge clk);
        hold_b = 1'b0; hold_r = 1'b0; rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_pulse", (wr_pulses - w0) + (rd_pulses - r0), 64'd0);
        check("midrst_dla_cleared", dla_data, 64'h0);

        w0 = wr_pulses; r0 = rd_pulses;
        wr_addr = 32'h7000; rd_addr = 32'h8000; pp_data = 64'h0F1E2D3C4B5A6978;
        rdata_cfg = 64'h1122334455667788;
        pulse_req(2'b11);
        check("restart_awaddr", cap_awaddr, 64'h7000);
        check("restart_wdata", cap_wdata, 64'h0F1E2D3C4B5A6978);
        check("restart_araddr", cap_araddr, 64'h8000);
        check("restart_dla", dla_data, 64'h1122334455667788);
        check("restart_pulses", {32'(wr_pulses - w0), 32'(rd_pulses - r0)}, {32'd1, 32'd1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
